// File: rtl/mouse_receiver.sv
// PS/2 device-to-host receiver: synchronises the mouse clock and data lines, deframes one
// 11-bit frame, checks parity and stop bit, and pulses BYTE_READY with the byte and error code.
module mouse_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);
  localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t r_state, w_next;

  logic       r_clk_s1, r_clk_s2, r_clk_d;
  logic       r_dat_s1, r_dat_s2;
  logic [2:0] r_cnt;
  logic [7:0] r_sr;
  logic       r_par;
  logic [15:0] r_wd;
  logic [7:0] r_byte;
  logic [1:0] r_err;
  logic       r_ready;
  logic       w_fall, w_timeout, w_done;

  assign w_fall    = r_clk_d & ~r_clk_s2;
  // An edge in the same cycle as expiry takes priority: the bit is accepted.
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_wd == TO - 16'd1);

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      IDLE:   if (w_fall && READ_ENABLE && !r_dat_s2) w_next = DATA;
      DATA:   if (w_fall && r_cnt == 3'd7) w_next = PARITY;
      PARITY: if (w_fall) w_next = STOP;
      STOP:   if (w_fall) begin
                w_next = IDLE;
                w_done = 1'b1;
              end
      default: w_next = IDLE;
    endcase
    if (w_timeout) w_next = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_cnt    <= '0;
      r_sr     <= '0;
      r_par    <= 1'b0;
      r_wd     <= '0;
      r_byte   <= '0;
      r_err    <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_clk_s1 <= CLK_MOUSE_IN;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= DATA_MOUSE_IN;
      r_dat_s2 <= r_dat_s1;
      r_ready  <= w_done;

      if (r_state == IDLE || w_fall || w_timeout) r_wd <= '0;
      else                                        r_wd <= r_wd + 16'd1;

      if (r_state == IDLE && w_next == DATA) r_cnt <= '0;
      if (r_state == DATA && w_fall) begin
        r_sr[r_cnt] <= r_dat_s2;
        r_cnt       <= r_cnt + 3'd1;
      end
      if (r_state == PARITY && w_fall) r_par <= r_dat_s2;

      // Odd parity: the nine bits must contain an odd number of ones.
      if (w_done) begin
        r_byte <= r_sr;
        r_err  <= {~r_dat_s2, ~(^r_sr ^ r_par)};
      end
    end
  end

  assign BYTE_READ       = r_byte;
  assign BYTE_ERROR_CODE = r_err;
  assign BYTE_READY      = r_ready;
endmodule

// File: tb/tb_mouse_receiver.sv
// Scoreboard bench for mouse_receiver: frame-level reference model pushes expected results,
// an independent monitor pops them on every BYTE_READY pulse.
module tb_mouse_receiver;
  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_m, dat_m, rd_en;
  logic [7:0] byte_rd;
  logic [1:0] err_code;
  logic       ready;

  mouse_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .RESET(rst_n), .CLK_MOUSE_IN(clk_m), .DATA_MOUSE_IN(dat_m),
    .READ_ENABLE(rd_en), .BYTE_READ(byte_rd), .BYTE_ERROR_CODE(err_code), .BYTE_READY(ready)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] sb[$];
  logic [7:0] last_byte = 8'h00;
  logic [1:0] last_code = 2'b00;
  logic       prev_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a whole frame started with READ_ENABLE high yields one result;
  // parity is good when data plus parity bit hold an odd count of ones.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int nbits, input bit drop_en, input int h);
    logic [10:0] f;
    logic [1:0]  code;
    f = {stp, par, d, 1'b0};
    if (rd_en && nbits == 11) begin
      code[0] = (($countones(d) + int'(par)) % 2) == 0;
      code[1] = (stp == 1'b0);
      sb.push_back({code, d});
      last_byte = d;
      last_code = code;
    end
    for (int i = 0; i < nbits; i++) begin
      dat_m = f[i];
      wait_cyc(h);
      clk_m = 1'b0;
      wait_cyc(h);
      clk_m = 1'b1;
      if (i == 0 && drop_en) rd_en = 1'b0;
    end
    dat_m = 1'b1;
    wait_cyc(h);
  endtask

  always @(negedge clk) begin
    if (rst_n && ready) begin
      chk("ready_one_cycle", {31'd0, prev_ready}, 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: byte 0x%0h code %0b with nothing expected", byte_rd, err_code);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        chk("byte_read", {24'd0, byte_rd}, {24'd0, e[7:0]});
        chk("error_code", {30'd0, err_code}, {30'd0, e[9:8]});
      end
    end
    prev_ready = ready;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic       p, s, e;
    rst_n = 1'b0; clk_m = 1'b1; dat_m = 1'b1; rd_en = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    chk("reset_byte", {24'd0, byte_rd}, 32'd0);
    chk("reset_code", {30'd0, err_code}, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    wait_cyc(1);
    rst_n = 1'b1;
    wait_cyc(5);

    send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b0, 6);
    send_frame(8'h08, 1'b0, 1'b1, 11, 1'b0, 6);
    send_frame(8'hAA, 1'b0, 1'b1, 11, 1'b0, 6);
    send_frame(8'h00, 1'b1, 1'b0, 11, 1'b0, 6);
    send_frame(8'h03, 1'b0, 1'b0, 11, 1'b0, 4);

    // Partial frame abandoned by the watchdog
    send_frame(8'h5C, 1'b0, 1'b1, 5, 1'b0, 6);
    wait_cyc(TO + 10);
    chk("timeout_byte_hold", {24'd0, byte_rd}, {24'd0, last_byte});
    chk("timeout_code_hold", {30'd0, err_code}, {30'd0, last_code});
    send_frame(8'hF4, 1'b0, 1'b1, 11, 1'b0, 6);

    rd_en = 1'b0;
    send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b0, 6);
    rd_en = 1'b1;
    send_frame(8'hAA, 1'b1, 1'b1, 11, 1'b1, 6);
    rd_en = 1'b1;

    // Reset mid-frame after D3
    send_frame(8'h3C, 1'b1, 1'b1, 5, 1'b0, 6);
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    last_byte = 8'h00;
    last_code = 2'b00;
    @(negedge clk);
    chk("midreset_byte", {24'd0, byte_rd}, 32'd0);
    chk("midreset_code", {30'd0, err_code}, 32'd0);
    chk("midreset_ready", {31'd0, ready}, 32'd0);
    wait_cyc(4);
    send_frame(8'h55, 1'b1, 1'b1, 11, 1'b0, 5);

    // One-cycle clock glitch with data high while idle
    clk_m = 1'b0;
    wait_cyc(1);
    clk_m = 1'b1;
    wait_cyc(10);
    send_frame(8'h08, 1'b0, 1'b1, 11, 1'b0, 6);

    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ($countones(d) % 2 == 0 ? 1'b0 : 1'b1)
                                      : ($countones(d) % 2 == 0 ? 1'b1 : 1'b0);
      s = ($urandom_range(0, 6) != 0);
      e = ($urandom_range(0, 4) != 0);
      rd_en = e;
      send_frame(d, p, s, 11, 1'b0, $urandom_range(4, 8));
    end
    rd_en = 1'b1;

    wait_cyc(50);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
